// File: rtl/iddr_pkg.sv
// Shared alignment FSM states and lock/settle constants for iddr_deser.
package iddr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    SETTLE,
    LOCKED
  } align_state_t;

  localparam int unsigned LOCK_CNT    = 4;
  localparam int unsigned SETTLE_CNT  = 2;
  localparam int unsigned ALIGN_CNT_W = 2;

endpackage

// File: rtl/iddr_deser_lane.sv
// One deserialiser lane: DDR pair history register and slip-selected word window.
module iddr_deser_lane #(
  parameter int unsigned RATIO  = 2,
  parameter bit          SWAP   = 1'b0,
  parameter int unsigned SLIP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                da,
  input  logic                db,
  input  logic                load,
  input  logic [SLIP_W-1:0]   slip_pos,
  output logic [2*RATIO-1:0]  word_c,
  output logic [2*RATIO-1:0]  word
);

  localparam int unsigned WORD_W = 2 * RATIO;
  localparam int unsigned HIST_W = 4 * RATIO;

  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_next;

  // Newest bits enter at the MSB so the oldest bit of a window lands in its LSB.
  always_comb begin
    hist_next = SWAP ? {da, db, hist[HIST_W-1:2]} : {db, da, hist[HIST_W-1:2]};
    word_c    = WORD_W'(hist_next >> (WORD_W - 32'(slip_pos)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      word <= '0;
    end else begin
      if (ce)   hist <= hist_next;
      if (load) word <= word_c;
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// IDDR output deserialiser with bitslip; optional lane-0 auto alignment
// compiled in with IDDR_DESER_ALIGN_EN.
module iddr_deser
  import iddr_pkg::*;
#(
  parameter int unsigned        WIDTH     = 1,
  parameter int unsigned        RATIO     = 2,
  parameter bit                 SWAP      = 1'b0,
  parameter logic [2*RATIO-1:0] TRAIN_PAT = '0
) (
  input  logic                      SCLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic [WIDTH-1:0]          DA,
  input  logic [WIDTH-1:0]          DB,
  input  logic                      BITSLIP,
  input  logic                      ALIGN_START,
  output logic [WIDTH*2*RATIO-1:0]  Q,
  output logic                      Q_VALID,
  output logic                      ALIGNED
);

  localparam int unsigned WORD_W = 2 * RATIO;
  localparam int unsigned SLIP_W = $clog2(WORD_W);
  localparam int unsigned PH_W   = $clog2(RATIO);

  logic [PH_W-1:0]              phase;
  logic [SLIP_W-1:0]            slip_pos;
  logic                         load;
  logic                         int_slip;
  logic [WIDTH-1:0][WORD_W-1:0] win_c;
  logic                         unused_win;

  assign load       = CE && (phase == PH_W'(RATIO - 1));
  assign unused_win = ^win_c;

  // Word phase counter, slip position and valid strobe.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      phase    <= '0;
      slip_pos <= '0;
      Q_VALID  <= 1'b0;
    end else begin
      Q_VALID <= load;
      if (CE) begin
        phase <= load ? '0 : phase + PH_W'(1);
        if (BITSLIP || int_slip)
          slip_pos <= (slip_pos == SLIP_W'(WORD_W - 1)) ? '0 : slip_pos + SLIP_W'(1);
      end
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    iddr_deser_lane #(
      .RATIO  (RATIO),
      .SWAP   (SWAP),
      .SLIP_W (SLIP_W)
    ) u_lane (
      .clk      (SCLK),
      .rst      (RST),
      .ce       (CE),
      .da       (DA[n]),
      .db       (DB[n]),
      .load     (load),
      .slip_pos (slip_pos),
      .word_c   (win_c[n]),
      .word     (Q[n*WORD_W +: WORD_W])
    );
  end

`ifdef IDDR_DESER_ALIGN_EN
  align_state_t           state;
  align_state_t           state_next;
  logic [ALIGN_CNT_W-1:0] cnt;
  logic [ALIGN_CNT_W-1:0] cnt_next;
  logic                   aligned_next;
  logic                   match_c;

  // Lane 0 is judged on the word being loaded, so a slip lands before the next load.
  assign match_c = (win_c[0] == TRAIN_PAT);

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      ALIGNED <= 1'b0;
    end else if (CE) begin
      state   <= state_next;
      cnt     <= cnt_next;
      ALIGNED <= aligned_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (ALIGN_START) begin
      state_next = SEARCH;
      cnt_next   = '0;
    end else if (load) begin
      case (state)
        SEARCH: begin
          if (!match_c) begin
            state_next = SETTLE;
            cnt_next   = '0;
          end else if (cnt == ALIGN_CNT_W'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ALIGN_CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == ALIGN_CNT_W'(SETTLE_CNT - 1)) begin
            state_next = SEARCH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ALIGN_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    int_slip     = 1'b0;
    aligned_next = (state_next == LOCKED);
    if (load && !ALIGN_START && (state == SEARCH) && !match_c) int_slip = 1'b1;
  end
`else
  logic unused_align;

  assign ALIGNED      = 1'b0;
  assign int_slip     = 1'b0;
  assign unused_align = ^{ALIGN_START, TRAIN_PAT};
`endif

endmodule

// File: tb/tb_iddr_deser.sv
// Self-checking bench for iddr_deser: three configurations against a bit-stream reference model.
module tb_iddr_deser;

  localparam int S_IDLE   = 0;
  localparam int S_SEARCH = 1;
  localparam int S_SETTLE = 2;
  localparam int S_LOCKED = 3;
  localparam int MAXB     = 8192;

  logic SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  logic        rst, ce, bitslip, align_start;
  logic        da0, db0;
  logic [3:0]  da2, db2;
  logic [3:0]  q0, q1;
  logic [63:0] q2;
  logic        v0, v1, v2, al0, al1, al2;

  iddr_deser #(.WIDTH(1), .RATIO(2), .SWAP(1'b0), .TRAIN_PAT(4'hD)) dut0 (
    .SCLK(SCLK), .RST(rst), .CE(ce), .DA(da0), .DB(db0), .BITSLIP(bitslip),
    .ALIGN_START(align_start), .Q(q0), .Q_VALID(v0), .ALIGNED(al0));

  iddr_deser #(.WIDTH(1), .RATIO(2), .SWAP(1'b1)) dut1 (
    .SCLK(SCLK), .RST(rst), .CE(ce), .DA(da0), .DB(db0), .BITSLIP(bitslip),
    .ALIGN_START(1'b0), .Q(q1), .Q_VALID(v1), .ALIGNED(al1));

  iddr_deser #(.WIDTH(4), .RATIO(8), .SWAP(1'b0)) dut2 (
    .SCLK(SCLK), .RST(rst), .CE(ce), .DA(da2), .DB(db2), .BITSLIP(bitslip),
    .ALIGN_START(1'b0), .Q(q2), .Q_VALID(v2), .ALIGNED(al2));

  // Reference model: every bit received since reset, per lane stream, oldest first.
  bit          strm [6][MAXB];
  int          len [6];
  int          cecnt [3];
  int          slip [3];
  logic [63:0] exp_q [3];
  logic        exp_v [3];
  int          ratio [3] = '{2, 2, 8};
  int          lanes [3] = '{1, 1, 4};
  int          base  [3] = '{0, 1, 2};
  bit          swp   [3] = '{1'b0, 1'b1, 1'b0};
  int          fsm, mcnt;
  logic        exp_al;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 6; s++) len[s] = 0;
    for (int k = 0; k < 3; k++) begin
      cecnt[k] = 0; slip[k] = 0; exp_q[k] = '0; exp_v[k] = 1'b0;
    end
    fsm = S_IDLE; mcnt = 0; exp_al = 1'b0;
  endtask

  task automatic model_edge();
    logic a, b, islip;
    int   sid, r, idx;
    for (int k = 0; k < 3; k++) begin
      if (!ce) begin
        exp_v[k] = 1'b0;
        continue;
      end
      r = ratio[k];
      for (int l = 0; l < lanes[k]; l++) begin
        a   = (k == 2) ? da2[l] : da0;
        b   = (k == 2) ? db2[l] : db0;
        sid = base[k] + l;
        if (len[sid] < MAXB - 2) begin
          strm[sid][len[sid]]     = swp[k] ? b : a;
          strm[sid][len[sid] + 1] = swp[k] ? a : b;
          len[sid] += 2;
        end
      end
      cecnt[k]++;
      exp_v[k] = (cecnt[k] % r == 0);
      if (exp_v[k]) begin
        for (int l = 0; l < lanes[k]; l++) begin
          sid = base[k] + l;
          for (int i = 0; i < 2 * r; i++) begin
            idx = len[sid] - slip[k] - 2 * r + i;
            exp_q[k][l * 2 * r + i] = (idx >= 0) ? strm[sid][idx] : 1'b0;
          end
        end
      end
      islip = 1'b0;
`ifdef IDDR_DESER_ALIGN_EN
      if (k == 0) begin
        if (align_start) begin
          fsm = S_SEARCH; mcnt = 0;
        end else if (exp_v[0]) begin
          if (fsm == S_SEARCH) begin
            if (exp_q[0][3:0] == 4'hD) begin
              mcnt++;
              if (mcnt == 4) begin fsm = S_LOCKED; mcnt = 0; end
            end else begin
              islip = 1'b1; fsm = S_SETTLE; mcnt = 0;
            end
          end else if (fsm == S_SETTLE) begin
            mcnt++;
            if (mcnt == 2) begin fsm = S_SEARCH; mcnt = 0; end
          end
        end
        exp_al = (fsm == S_LOCKED);
      end
`endif
      if (bitslip || islip) slip[k] = (slip[k] + 1) % (2 * r);
    end
  endtask

  // Called at a falling edge with inputs set; checks all outputs after the rising edge.
  task automatic step();
    model_edge();
    @(posedge SCLK); #1;
    check("q_valid0", 64'(v0), 64'(exp_v[0]));
    check("q_valid1", 64'(v1), 64'(exp_v[1]));
    check("q_valid2", 64'(v2), 64'(exp_v[2]));
    check("q0", 64'(q0), exp_q[0]);
    check("q1", 64'(q1), exp_q[1]);
    check("q2", q2, exp_q[2]);
    check("aligned0", 64'(al0), 64'(exp_al));
    check("aligned1", 64'(al1), 64'd0);
    check("aligned2", 64'(al2), 64'd0);
    @(negedge SCLK);
  endtask

  task automatic drive(input logic a, input logic b);
    da0 = a; db0 = b;
    da2 = 4'($urandom); db2 = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_q0", 64'(q0), 64'd0);
    check("rst_q2", q2, 64'd0);
    check("rst_valid0", 64'(v0), 64'd0);
    check("rst_aligned0", 64'(al0), 64'd0);
    @(negedge SCLK);
    rst = 1'b0;
  endtask

  logic [15:0] pat [4] = '{16'hA5C3, 16'h1234, 16'hFFFE, 16'h0F81};
  int          p;

  initial begin
    rst = 1'b1; ce = 1'b0; bitslip = 1'b0; align_start = 1'b0;
    da0 = 1'b0; db0 = 1'b0; da2 = '0; db2 = '0;
    model_reset();
    @(negedge SCLK);
    do_reset();

    // Basic word, both pair orders, then one bitslip.
    ce = 1'b1;
    drive(1'b1, 1'b0); step();
    drive(1'b1, 1'b1); step();
    check("first_q_swap0", 64'(q0), 64'hD);
    check("first_valid", 64'(v0), 64'd1);
    check("first_q_swap1", 64'(q1), 64'hE);
    drive(1'b1, 1'b0); step();
    check("valid_one_cycle", 64'(v0), 64'd0);
    check("q_hold", 64'(q0), 64'hD);
    drive(1'b1, 1'b1); step();
    bitslip = 1'b1; drive(1'b1, 1'b0); step();
    bitslip = 1'b0; drive(1'b1, 1'b1); step();
    for (int w = 0; w < 2; w++) begin
      drive(1'b1, 1'b0); step();
      drive(1'b1, 1'b1); step();
    end
    check("slip_q", 64'(q0), 64'hB);

    // CE pause mid-word, then reset mid-word.
    do_reset();
    ce = 1'b1; drive(1'b1, 1'b0); step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom)); step();
      check("ce_hold_valid", 64'(v0), 64'd0);
    end
    ce = 1'b1; drive(1'b1, 1'b1); step();
    check("ce_resume_valid", 64'(v0), 64'd1);
    check("ce_resume_q", 64'(q0), 64'hD);
    drive(1'b0, 1'b1); step();
    do_reset();
    drive(1'b1, 1'b0); step();
    check("post_rst_no_valid", 64'(v0), 64'd0);
    drive(1'b1, 1'b1); step();
    check("post_rst_valid", 64'(v0), 64'd1);
    check("post_rst_q", 64'(q0), 64'hD);

    // Wide configuration: independent per-lane words.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom), 1'($urandom));
      for (int l = 0; l < 4; l++) begin
        da2[l] = pat[l][2 * i];
        db2[l] = pat[l][2 * i + 1];
      end
      step();
    end
    check("wide_valid", 64'(v2), 64'd1);
    for (int l = 0; l < 4; l++) check("wide_lane", 64'(q2[l * 16 +: 16]), 64'(pat[l]));

    // Automatic alignment from slip offset 3.
    do_reset();
    p = 0;
    for (int i = 0; i < 3; i++) begin
      bitslip = 1'b1; drive(1'b1, (p % 2) == 1); step(); p++;
    end
    bitslip = 1'b0;
    align_start = 1'b1; drive(1'b1, (p % 2) == 1); step(); p++;
    align_start = 1'b0;
`ifdef IDDR_DESER_ALIGN_EN
    for (int i = 0; i < 100 && !al0; i++) begin
      drive(1'b1, (p % 2) == 1); step(); p++;
    end
    check("align_lock", 64'(al0), 64'd1);
    check("align_slip_q", 64'(q0), 64'hD);
    align_start = 1'b1; drive(1'b1, (p % 2) == 1); step(); p++;
    align_start = 1'b0;
    check("align_restart", 64'(al0), 64'd0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (p % 2) == 1); step(); p++;
    end
    check("no_align", 64'(al0), 64'd0);
`endif

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 150) do_reset();
      ce          = ($urandom_range(0, 9) != 0);
      bitslip     = ($urandom_range(0, 19) == 0);
      align_start = ($urandom_range(0, 199) == 0);
      drive(1'($urandom), 1'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
